// File: rtl/axil2iob_arb.sv
// ---------------------------------------------------------------------------
// axil2iob_arb
//
// Bridges an AXI4-Lite slave port onto a single IOb native master bus.
// Only one transaction is in flight at a time. A write is accepted only
// when AW and W are presented together. A read is accepted when AR is
// presented. When both are pending in the same cycle, an arbiter picks one.
// That arbiter is either round-robin or read-first, chosen by RD_PRIO.
//
// The accepted request is registered and driven onto the IOb bus one cycle
// after the AXI handshake. valid is then held until the peripheral pulses
// ready. If ready does not arrive within 2**TIMEOUT_W-1 cycles, the request
// is abandoned and the transaction is answered with SLVERR.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   axil_aw* / axil_w*        write address / data channels (slave side)
//   axil_b*                   write response channel
//   axil_ar*                  read address channel
//   axil_r*                   read data / response channel
//   valid, addr, wdata, wstrb IOb request (wstrb == 0 marks a read)
//   rdata, ready              IOb completion; rdata is sampled with ready
// ---------------------------------------------------------------------------
module axil2iob_arb #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int TIMEOUT_W   = 8,
  parameter int RD_PRIO     = 0
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr,
  input  logic                     axil_awvalid,
  output logic                     axil_awready,
  input  logic [AXIL_DATA_W-1:0]   axil_wdata,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb,
  input  logic                     axil_wvalid,
  output logic                     axil_wready,
  output logic [1:0]               axil_bresp,
  output logic                     axil_bvalid,
  input  logic                     axil_bready,

  input  logic [AXIL_ADDR_W-1:0]   axil_araddr,
  input  logic                     axil_arvalid,
  output logic                     axil_arready,
  output logic [AXIL_DATA_W-1:0]   axil_rdata,
  output logic [1:0]               axil_rresp,
  output logic                     axil_rvalid,
  input  logic                     axil_rready,

  output logic                     valid,
  output logic [AXIL_ADDR_W-1:0]   addr,
  output logic [AXIL_DATA_W-1:0]   wdata,
  output logic [AXIL_DATA_W/8-1:0] wstrb,
  input  logic [AXIL_DATA_W-1:0]   rdata,
  input  logic                     ready
);

  localparam int STRB_W = AXIL_DATA_W / 8;
  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = '1;
  localparam logic [TIMEOUT_W-1:0] TMO_ONE   = TIMEOUT_W'(1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    BRSP = 3'd3,
    RRSP = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   cnt_inc;

  logic                   valid_q, valid_d;
  logic [AXIL_ADDR_W-1:0] addr_q, addr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;

  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;

  logic                   wr_pend, rd_pend;
  logic                   grant_wr, grant_rd;

  // Arbitration. rr_q set means the previous grant was a write, so a
  // contended cycle should now go to the read side.
  always_comb begin
    wr_pend  = axil_awvalid & axil_wvalid;
    rd_pend  = axil_arvalid;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == IDLE) begin
      if (wr_pend && rd_pend) begin
        if (RD_PRIO != 0) begin
          grant_rd = 1'b1;
        end else if (rr_q) begin
          grant_rd = 1'b1;
        end else begin
          grant_wr = 1'b1;
        end
      end else if (wr_pend) begin
        grant_wr = 1'b1;
      end else if (rd_pend) begin
        grant_rd = 1'b1;
      end
    end
  end

  // The AXI ready signals are combinational, so a grant completes the
  // handshake in the same cycle the request is seen.
  assign axil_awready = grant_wr;
  assign axil_wready  = grant_wr;
  assign axil_arready = grant_rd;

  assign cnt_inc = cnt_q + TMO_ONE;

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_wr) begin
          rr_d    = 1'b1;
          addr_d  = axil_awaddr;
          wdata_d = axil_wdata;
          wstrb_d = axil_wstrb;
          valid_d = 1'b1;
          state_d = WR;
        end else if (grant_rd) begin
          rr_d    = 1'b0;
          addr_d  = axil_araddr;
          wdata_d = '0;
          wstrb_d = '0;
          valid_d = 1'b1;
          state_d = RD;
        end
      end

      WR, RD: begin
        // ready takes precedence over the timeout in the same cycle.
        if (ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          if (state_q == WR) begin
            bresp_d  = RESP_OKAY;
            bvalid_d = 1'b1;
            state_d  = BRSP;
          end else begin
            rdata_d  = rdata;
            rresp_d  = RESP_OKAY;
            rvalid_d = 1'b1;
            state_d  = RRSP;
          end
        end else if (cnt_inc == TMO_LIMIT) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          if (state_q == WR) begin
            bresp_d  = RESP_SLVERR;
            bvalid_d = 1'b1;
            state_d  = BRSP;
          end else begin
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            rvalid_d = 1'b1;
            state_d  = RRSP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      BRSP: begin
        if (axil_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      RRSP: begin
        if (axil_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset aborts any transaction in progress
  // without producing a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign valid       = valid_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign axil_bvalid = bvalid_q;
  assign axil_bresp  = bresp_q;
  assign axil_rvalid = rvalid_q;
  assign axil_rresp  = rresp_q;
  assign axil_rdata  = rdata_q;

endmodule
